// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared mode encodings and midscale helper for the DAC streamer
package dac_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_CONST  = 2'd1,
    MODE_RAMP   = 2'd2,
    MODE_STREAM = 2'd3
  } dac_mode_e;

  // Offset-binary midscale for a dw-bit converter: MSB set, rest clear.
  function automatic logic [31:0] midscale(input int unsigned dw);
    return 32'd1 << (dw - 1);
  endfunction

endpackage

// File: rtl/dac_stream_out_if.sv
// rtl/dac_stream_out_if.sv - sample stream handshake bundle
interface dac_stream_out_if #(
  parameter int NCH = 2,
  parameter int DW  = 14
);
  logic [NCH*DW-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/dac_fifo.sv
// rtl/dac_fifo.sv - first-word-fall-through sample FIFO with registered flags
module dac_fifo #(
  parameter int W  = 28,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  localparam int            DEPTH   = 1 << AW;
  localparam logic [AW:0]   DEPTH_C = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d;

  // Storage has no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  // Next pointers, occupancy and flags; simultaneous push/pop keeps the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
  end

  // Pointer, count and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign level   = count_q;

endmodule

// File: rtl/dac_oddr.sv
// rtl/dac_oddr.sv - same-edge output DDR register model
module dac_oddr #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d1,
  input  logic d2,
  output logic q
);
  logic d1_q, d2_q;

  // Both halves are captured on the rising edge; d1 drives the high phase, d2 the low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1_q <= RST_VAL;
      d2_q <= RST_VAL;
    end else begin
      d1_q <= d1;
      d2_q <= d2;
    end
  end

  assign q = clk ? d1_q : d2_q;

endmodule

// File: rtl/dac_stream_out.sv
// rtl/dac_stream_out.sv - multi-channel DAC sample generator with stream FIFO and DDR pin drivers
module dac_stream_out
  import dac_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int DW      = 14,
  parameter int FIFO_AW = 4,
  parameter int TWOS_IN = 1
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [2*NCH-1:0]   mode,
  input  logic [NCH*DW-1:0]  const_val,
  input  logic [NCH*DW-1:0]  ramp_step,
  dac_stream_out_if.slave    s_axis,
  output logic               underflow,
  input  logic               underflow_clr,
  output logic [15:0]        underflow_cnt,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [NCH-1:0]     da_clk,
  output logic [NCH-1:0]     da_wrt,
  output logic [NCH*DW-1:0]  da_data
);
  localparam logic [31:0]   MID_W = midscale(DW);
  localparam logic [DW-1:0] MID   = MID_W[DW-1:0];

  // Two's complement sources become offset binary by flipping the MSB.
  function automatic logic [DW-1:0] to_dac(input logic [DW-1:0] v);
    return (TWOS_IN != 0) ? (v ^ MID) : v;
  endfunction

  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [NCH*DW-1:0]      fifo_rd_data;
  logic                   any_stream, uf_event;

  logic                   boot_q, boot_d, rdy_en_q, rdy_en_d;
  logic [NCH-1:0][DW-1:0] sample_q, sample_d;
  logic [NCH-1:0][DW-1:0] acc_q, acc_d;
  logic [NCH-1:0][1:0]    prev_mode_q, prev_mode_d;
  logic                   uf_q, uf_d;
  logic [15:0]            uf_cnt_q, uf_cnt_d;

  // One FIFO entry feeds all channels, so any STREAM channel drives the pop.
  always_comb begin
    any_stream = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (mode[2*i +: 2] == MODE_STREAM) any_stream = 1'b1;
    end
  end

  assign s_axis.s_ready = rdy_en_q & ~fifo_full;
  assign fifo_push      = s_axis.s_valid & s_axis.s_ready;
  assign fifo_pop       = enable & any_stream & ~fifo_empty;
  assign uf_event       = enable & any_stream & fifo_empty;

  dac_fifo #(
    .W  (NCH*DW),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (sys_clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_push),
    .wr_data (s_axis.s_data),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Per-channel source selection; the ramp restarts from zero on entry into RAMP.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      prev_mode_d[i] = mode[2*i +: 2];
      acc_d[i]       = acc_q[i];
      sample_d[i]    = sample_q[i];
      if ((mode[2*i +: 2] == MODE_RAMP) && (prev_mode_q[i] != MODE_RAMP)) begin
        acc_d[i] = '0;
      end else if (enable && (mode[2*i +: 2] == MODE_RAMP)) begin
        acc_d[i] = acc_q[i] + ramp_step[i*DW +: DW];
      end
      if (!enable) begin
        sample_d[i] = MID;
      end else begin
        case (dac_mode_e'(mode[2*i +: 2]))
          MODE_OFF:    sample_d[i] = MID;
          MODE_CONST:  sample_d[i] = to_dac(const_val[i*DW +: DW]);
          MODE_RAMP:   sample_d[i] = to_dac(acc_d[i]);
          MODE_STREAM: if (fifo_pop) sample_d[i] = to_dac(fifo_rd_data[i*DW +: DW]);
        endcase
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        sample_q[i]    <= MID;
        acc_q[i]       <= '0;
        prev_mode_q[i] <= MODE_OFF;
      end
    end else begin
      sample_q    <= sample_d;
      acc_q       <= acc_d;
      prev_mode_q <= prev_mode_d;
    end
  end

  // Sticky underflow with saturating count; a clear wins over a same-cycle event.
  always_comb begin
    uf_d     = uf_q;
    uf_cnt_d = uf_cnt_q;
    if (underflow_clr) begin
      uf_d     = 1'b0;
      uf_cnt_d = '0;
    end else if (uf_event) begin
      uf_d = 1'b1;
      if (uf_cnt_q != 16'hFFFF) uf_cnt_d = uf_cnt_q + 16'd1;
    end
  end

  // Underflow registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      uf_q     <= 1'b0;
      uf_cnt_q <= '0;
    end else begin
      uf_q     <= uf_d;
      uf_cnt_q <= uf_cnt_d;
    end
  end

  // Two-stage start-up so the stream is only accepted from the second edge after reset.
  always_comb begin
    boot_d   = 1'b1;
    rdy_en_d = boot_q;
  end

  // Start-up registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      boot_q   <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      boot_q   <= boot_d;
      rdy_en_q <= rdy_en_d;
    end
  end

  assign underflow     = uf_q;
  assign underflow_cnt = uf_cnt_q;

  // Pin drivers: inverted forwarded clock, write strobe held high out of reset, data bits.
  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    dac_oddr #(.RST_VAL(1'b0)) u_clk_oddr (
      .clk   (sys_clk),
      .rst_n (rst_n),
      .d1    (1'b0),
      .d2    (1'b1),
      .q     (da_clk[ch])
    );
    dac_oddr #(.RST_VAL(1'b0)) u_wrt_oddr (
      .clk   (sys_clk),
      .rst_n (rst_n),
      .d1    (1'b1),
      .d2    (1'b1),
      .q     (da_wrt[ch])
    );
    for (genvar b = 0; b < DW; b++) begin : g_bit
      dac_oddr #(.RST_VAL(MID[b])) u_dat_oddr (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .d1    (sample_q[ch][b]),
        .d2    (sample_q[ch][b]),
        .q     (da_data[ch*DW + b])
      );
    end
  end

endmodule

// File: doc/dac_stream_out.md
DAC_STREAM_OUT -- requirements
Module: dac_stream_out

Interface
REQ-001 SHALL take parameter NCH, default 2: number of DAC channels.
REQ-002 SHALL take parameter DW, default 14: DAC data width.
REQ-003 SHALL take parameter FIFO_AW, default 4: FIFO depth is 2^FIFO_AW samples.
REQ-004 SHALL take parameter TWOS_IN, default 1: 1 means sample sources are two's complement and the MSB is inverted to give offset binary.
REQ-005 SHALL have port sys_clk, input, 1 bit: single clock for all logic.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port enable, input, 1 bit: global output enable.
REQ-008 SHALL have port mode, input, 2*NCH bits: per-channel mode (0 OFF, 1 CONST, 2 RAMP, 3 STREAM).
REQ-009 SHALL have port const_val, input, NCH*DW bits: per-channel constant.
REQ-010 SHALL have port ramp_step, input, NCH*DW bits: per-channel ramp increment.
REQ-011 SHALL have port s_data, input, NCH*DW bits: stream sample, all channels aligned.
REQ-012 SHALL have port s_valid, input, 1 bit; and port s_ready, output, 1 bit: stream handshake.
REQ-013 SHALL have port underflow, output, 1 bit: sticky underflow flag.
REQ-014 SHALL have port underflow_clr, input, 1 bit: clears underflow and underflow_cnt.
REQ-015 SHALL have port underflow_cnt, output, 16 bits: saturating count of underflow cycles.
REQ-016 SHALL have port fifo_level, output, FIFO_AW+1 bits: current FIFO occupancy.
REQ-017 SHALL have port da_clk, output, NCH bits: forwarded DAC clock per channel.
REQ-018 SHALL have port da_wrt, output, NCH bits: DAC write strobe per channel.
REQ-019 SHALL have port da_data, output, NCH*DW bits: DAC data per channel.

Function
REQ-020 SHALL transfer a stream sample when s_valid and s_ready are both high on a sys_clk edge; s_ready SHALL equal "FIFO not full", registered.
REQ-021 SHALL produce one output sample per channel every sys_clk cycle while enable is 1.
REQ-022 SHALL pop one FIFO entry per cycle when enable is 1, the FIFO is non-empty and at least one channel is in STREAM mode.
REQ-023 SHALL drive midscale (MSB 1, all other bits 0) on a channel in OFF mode.
REQ-024 SHALL drive const_val (after format conversion) on a channel in CONST mode.
REQ-025 SHALL, in RAMP mode, add ramp_step to a DW-bit accumulator each cycle, wrapping modulo 2^DW.
REQ-026 SHALL clear the ramp accumulator to 0 on any cycle where the channel's mode changes into RAMP.
REQ-027 SHALL, on a STREAM channel with an empty FIFO, repeat the last sample, set underflow and increment underflow_cnt, saturating at 0xFFFF.
REQ-028 SHALL give underflow_clr priority over a simultaneous underflow event, so the result is flag 0 and count 0.
REQ-029 SHALL, when enable is 0, hold all channels at midscale, pop nothing, freeze the ramp accumulators and report no underflow.
REQ-030 SHALL, on a simultaneous push and pop, leave fifo_level unchanged; a push when full and a pop when empty SHALL never occur.
REQ-031 SHALL, with TWOS_IN=1, invert the MSB of CONST, RAMP and STREAM values; OFF midscale is already offset binary and SHALL be left unchanged.
REQ-032 SHALL apply mode, const_val and ramp_step changes to the sample register one cycle later.
REQ-033 SHALL have a latency of 3 cycles from an accepted handshake to the value on the da_data pins, with an empty FIFO and STREAM already active: FIFO write, sample register, ODDR.
REQ-034 SHALL generate da_clk with an ODDR per channel (D1=0, D2=1, SAME_EDGE), giving a clock at the sys_clk rate, inverted.
REQ-035 SHALL drive every da_data bit and every da_wrt bit through an ODDR with D1=D2 equal to the registered value.

Reset
REQ-036 SHALL, while rst_n is low, force asynchronously: FIFO empty, s_ready 0, underflow 0, underflow_cnt 0, fifo_level 0, ramp accumulators 0, sample registers midscale, da_wrt 0.
REQ-037 SHALL raise da_wrt to 1 on the first sys_clk edge after rst_n deasserts.
REQ-038 SHALL raise s_ready on the second sys_clk edge after rst_n deasserts.
REQ-039 SHALL discard FIFO contents on a reset asserted mid-stream and SHALL return outputs to midscale within one cycle.

Structure
REQ-040 SHALL place the mode encodings (OFF, CONST, RAMP, STREAM) and a midscale constant function of DW in the shared package dac_pkg.
REQ-041 SHALL implement the FIFO as the sub-module dac_fifo (parameters: width and address width; registered full and empty flags; level output).
REQ-042 SHALL instantiate the ODDR primitives in the top level, inside generate loops.

Verification
REQ-043 SHALL cover the reset sequence: after reset release, da_data=0x2000 on both channels, da_wrt goes 0→1 on edge 1, and s_ready goes to 1 on edge 2.
REQ-044 SHALL cover CONST mode: const_val=0x0005 with TWOS_IN=1 puts 0x2005 on the pins within 2 cycles of the mode write.
REQ-045 SHALL cover RAMP mode: ramp_step=0x1000 gives 0x2000, 0x3000, 0x0000 (after wrap), 0x1000 in consecutive cycles on the pins.
REQ-046 SHALL cover STREAM mode: pushing 4 samples, then s_valid=0, shows all 4 in order; the 4th value then holds, underflow=1, and underflow_cnt increments each cycle.
REQ-047 SHALL cover FIFO full: with enable=0, pushing 16 samples drops s_ready to 0 and gives fifo_level=16; raising enable pops one sample per cycle and s_ready returns to 1.
REQ-048 SHALL cover simultaneous events: underflow_clr together with an underflow event gives underflow=0 and underflow_cnt=0; a reset during STREAM empties the FIFO and drives midscale within one cycle.
